// File: rtl/rle_stream_scheduler.sv
// rle_stream_scheduler
//
// Merges three run-length streams from the RLE encoder onto one 16-bit word
// link. Each stream lands in its own small FIFO; a round-robin arbiter pops
// one run per accepted output slot. After the encoder signals the end of a
// frame, the remaining runs drain and a single end-of-frame marker word is
// emitted before the next frame starts.
//
// Output word: {eof, id[1:0], frame[2:0], run[9:0]}
//   run word : eof=0, id=stream index, frame=frame counter, run=value
//   marker   : eof=1, id=2'b11,        frame=frame counter, run=0
//
// Ports
//   CLK        in   system clock, rising edge
//   RESET      in   asynchronous active-high reset
//   s_run      in   3 x RUN_W run lengths, index i = encoder stream i+1
//   s_valid    in   per-stream write strobe (no backpressure to encoder)
//   im_end     in   one-cycle frame-end strobe
//   out_data   out  16-bit word to the link
//   out_valid  out  out_data holds a word
//   out_ready  in   link accepts the word
//   overflow   out  sticky per-stream "run dropped this frame"
//   draining   out  high while draining or emitting the marker
//   dbg_state  out  current FSM state (0=RUN, 1=DRAIN, 2=EOF)
//
// Handshake: a word transfers on a rising edge where out_valid and out_ready
// are both high. While out_valid=1 and out_ready=0, out_data and out_valid
// hold. The output register refills whenever it is empty or being drained,
// so a continuously ready link sees one word per cycle.

module rle_stream_scheduler #(
    parameter int DEPTH = 4,
    parameter int RUN_W = 10
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [2:0][RUN_W-1:0] s_run,
    input  logic [2:0]            s_valid,
    input  logic                  im_end,
    output logic [15:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            overflow,
    output logic                  draining,
    output logic [1:0]            dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_EOF   = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // Per-stream FIFO storage and bookkeeping
    logic [RUN_W-1:0] mem    [3][DEPTH];
    logic [AW-1:0]    wr_ptr [3];
    logic [AW-1:0]    rd_ptr [3];
    logic [CW-1:0]    count  [3];

    logic [2:0]       fifo_empty;
    logic [2:0]       fifo_full;
    logic [2:0]       wr_en;
    logic [2:0]       pop;
    logic [2:0]       ovf_set;
    logic             all_empty;

    // Arbitration
    logic [1:0]       rr_ptr;      // last granted stream
    logic [1:0]       arb_cand;
    logic [1:0]       grant_id;
    logic             grant_valid;
    logic [RUN_W-1:0] pop_run;

    // Output control
    logic             load_en;
    logic             pop_ok;
    logic             eof_load;
    logic             eof_accept;
    logic             eof_sent;    // the marker currently sits in the output register
    logic [2:0]       frame;

    // ------------------------------------------------------------------
    // FIFO status
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            fifo_empty[i] = (count[i] == '0);
            fifo_full[i]  = (count[i] == CW'(DEPTH));
        end
    end

    assign all_empty = &fifo_empty;

    // ------------------------------------------------------------------
    // Round-robin arbiter: first non-empty stream after the last grant
    // ------------------------------------------------------------------
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = rr_ptr;
        arb_cand    = rr_ptr;
        for (int k = 0; k < 3; k++) begin
            arb_cand = (arb_cand == 2'd2) ? 2'd0 : arb_cand + 2'd1;
            if (!grant_valid && !fifo_empty[arb_cand]) begin
                grant_valid = 1'b1;
                grant_id    = arb_cand;
            end
        end
    end

    always_comb begin
        pop_run = '0;
        for (int i = 0; i < 3; i++) begin
            if (grant_id == 2'(i)) begin
                pop_run = mem[i][rd_ptr[i]];
            end
        end
    end

    assign load_en = !out_valid || out_ready;
    // Runs never share the output register with the marker: once in EOF the
    // FIFOs are already empty and stay empty until the next frame.
    assign pop_ok  = (state != ST_EOF) && load_en && grant_valid;

    always_comb begin
        pop = '0;
        if (pop_ok) begin
            pop[grant_id] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Writes and drops. A full FIFO that is popped in the same cycle has
    // room for the incoming run. Outside RUN every strobe is a drop; that
    // includes strobes during the marker cycle, since those runs are lost.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            if (state == ST_RUN) begin
                wr_en[i]   = s_valid[i] && (!fifo_full[i] || pop[i]);
                ovf_set[i] = s_valid[i] && fifo_full[i] && !pop[i];
            end else begin
                wr_en[i]   = 1'b0;
                ovf_set[i] = s_valid[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            if (wr_en[i]) begin
                mem[i][wr_ptr[i]] <= s_run[i];
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 3; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (wr_en[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + AW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                end
                count[i] <= count[i] + CW'(wr_en[i]) - CW'(pop[i]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        eof_load   = 1'b0;
        eof_accept = 1'b0;
        case (state)
            ST_RUN: begin
                if (im_end) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // All FIFOs empty means no pop can be pending this cycle.
                if (all_empty) begin
                    next_state = ST_EOF;
                end
            end
            ST_EOF: begin
                if (!eof_sent && load_en) begin
                    eof_load = 1'b1;
                end
                if (eof_sent && out_valid && out_ready) begin
                    eof_accept = 1'b1;
                    next_state = ST_RUN;
                end
            end
            default: begin
                next_state = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register, arbiter pointer, frame counter, overflow flags
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            rr_ptr    <= 2'd2;
            frame     <= '0;
            overflow  <= '0;
            eof_sent  <= 1'b0;
        end else begin
            if (pop_ok) begin
                out_data  <= {1'b0, grant_id, frame, pop_run};
                out_valid <= 1'b1;
                rr_ptr    <= grant_id;
            end else if (eof_load) begin
                out_data  <= {1'b1, 2'b11, frame, RUN_W'(0)};
                out_valid <= 1'b1;
            end else if (load_en) begin
                out_valid <= 1'b0;
            end

            if (eof_load) begin
                eof_sent <= 1'b1;
            end else if (eof_accept) begin
                eof_sent <= 1'b0;
            end

            // Accepting the marker starts a clean frame; the clear wins over
            // any drop flagged in the same cycle.
            if (eof_accept) begin
                frame    <= frame + 3'd1;
                overflow <= '0;
            end else begin
                overflow <= overflow | ovf_set;
            end
        end
    end

    assign draining  = (state == ST_DRAIN) || (state == ST_EOF);
    assign dbg_state = state;

endmodule

// File: tb/tb_rle_stream_scheduler.sv
// Directed testbench for rle_stream_scheduler. Inputs are driven 1 time unit
// after the rising edge; outputs are sampled at the same point, so each
// sample shows the result of the most recent edge.

module tb_rle_stream_scheduler;

    logic             CLK;
    logic             RESET;
    logic [2:0][9:0]  s_run;
    logic [2:0]       s_valid;
    logic             im_end;
    logic [15:0]      out_data;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       overflow;
    logic             draining;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    rle_stream_scheduler #(
        .DEPTH (4),
        .RUN_W (10)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .s_run     (s_run),
        .s_valid   (s_valid),
        .im_end    (im_end),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .draining  (draining),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------------------------
    // Clock and reset
    // ------------------------------------------------------------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RESET     = 1'b1;
        s_valid   = '0;
        im_end    = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        tick();
    endtask

    // Bounded wait for out_valid; ok=0 if the budget expires.
    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        RESET     = 1'b1;
        s_run     = '0;
        s_valid   = '0;
        im_end    = 1'b0;
        out_ready = 1'b0;
        #12;
        n_checks++;
        if ({out_valid, out_data, overflow, draining, dbg_state} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b data=%h ovf=%b drn=%b st=%0d, want all 0",
                     out_valid, out_data, overflow, draining, dbg_state);
        end
        tick();
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_single_run();
        out_ready  = 1'b1;
        s_run[0]   = 10'd37;
        s_valid    = 3'b001;
        tick();
        s_valid = '0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: out_valid=%b one edge early, want 0", out_valid);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0025) begin
            n_fail++;
            $display("FAIL single_word: got valid=%b data=%h, want 1 0025", out_valid, out_data);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_simultaneous();
        logic [15:0] exp_w [3];
        bit ok;
        exp_w[0] = 16'h0005;
        exp_w[1] = 16'h2006;
        exp_w[2] = 16'h4007;
        apply_reset();
        s_run   = {10'd7, 10'd6, 10'd5};
        s_valid = 3'b111;
        tick();
        s_valid = '0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            wait_valid(ok);
            n_checks++;
            if (!ok || out_data !== exp_w[i]) begin
                n_fail++;
                $display("FAIL simul_word%0d: got ok=%b data=%h, want %h", i, ok, out_data, exp_w[i]);
            end
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_idle: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_run[1] = 10'(11 + i);
            s_valid  = 3'b010;
            tick();
            if (i > 0) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== 16'h200B) begin
                    n_fail++;
                    $display("FAIL bp_hold%0d: got valid=%b data=%h, want 1 200b", i, out_valid, out_data);
                end
            end
        end
        s_valid = '0;
        n_checks++;
        if (overflow !== 3'b010) begin
            n_fail++;
            $display("FAIL bp_overflow: got %b, want 010", overflow);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp = 16'h2000 | 16'(11 + i);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                n_fail++;
                $display("FAIL bp_release%0d: got valid=%b data=%h, want 1 %h", i, out_valid, out_data, exp);
            end
            tick();
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drop_lost: out_valid=%b data=%h, want 0 (sixth run dropped)", out_valid, out_data);
        end
    endtask

    // Last grant was stream 1, so order is 2, 0, 1. Run 0 is forwarded as is.
    task automatic test_frame_end();
        logic [15:0] exp_w [4];
        bit ok;
        exp_w[0] = 16'h412C;
        exp_w[1] = 16'h0064;
        exp_w[2] = 16'h2000;
        exp_w[3] = 16'hE000;
        s_run   = {10'd300, 10'd0, 10'd100};
        s_valid = 3'b111;
        im_end  = 1'b1;
        tick();
        s_valid = '0;
        im_end  = 1'b0;
        n_checks++;
        if (draining !== 1'b1 || dbg_state !== 2'd1) begin
            n_fail++;
            $display("FAIL fe_drain_state: got drn=%b st=%0d, want 1 1", draining, dbg_state);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            wait_valid(ok);
            n_checks++;
            if (!ok || out_data !== exp_w[i]) begin
                n_fail++;
                $display("FAIL fe_word%0d: got ok=%b data=%h, want %h", i, ok, out_data, exp_w[i]);
            end
        end
        n_checks++;
        if (overflow !== 3'b010) begin
            n_fail++;
            $display("FAIL fe_ovf_before: got %b, want 010", overflow);
        end
        tick();
        n_checks++;
        if (overflow !== 3'b000 || draining !== 1'b0 || out_valid !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL fe_after_eof: got ovf=%b drn=%b valid=%b st=%0d, want 000 0 0 0",
                     overflow, draining, out_valid, dbg_state);
        end
        s_run[0] = 10'd9;
        s_valid  = 3'b001;
        tick();
        s_valid = '0;
        wait_valid(ok);
        n_checks++;
        if (!ok || out_data !== 16'h0409) begin
            n_fail++;
            $display("FAIL fe_next_frame: got ok=%b data=%h, want 0409", ok, out_data);
        end
        tick();
    endtask

    task automatic test_frame_wrap();
        logic [15:0] exp_w [9];
        bit ok;
        exp_w = '{16'hE000, 16'hE400, 16'hE800, 16'hEC00, 16'hF000,
                  16'hF400, 16'hF800, 16'hFC00, 16'hE000};
        apply_reset();
        for (int f = 0; f < 9; f++) begin
            im_end = 1'b1;
            tick();
            im_end = 1'b0;
            wait_valid(ok);
            n_checks++;
            if (!ok || out_data !== exp_w[f]) begin
                n_fail++;
                $display("FAIL wrap_eof%0d: got ok=%b data=%h, want %h", f, ok, out_data, exp_w[f]);
            end
            tick();
        end
    endtask

    // Frame counter is 1 here. A strobe in DRAIN is dropped and flagged; a
    // second im_end in DRAIN must not produce another marker.
    task automatic test_drain_drop();
        bit ok;
        bit extra;
        im_end = 1'b1;
        tick();
        s_run[2] = 10'd55;
        s_valid  = 3'b100;
        im_end   = 1'b1;
        tick();
        s_valid = '0;
        im_end  = 1'b0;
        wait_valid(ok);
        n_checks++;
        if (!ok || out_data !== 16'hE400) begin
            n_fail++;
            $display("FAIL drop_first_word: got ok=%b data=%h, want e400", ok, out_data);
        end
        n_checks++;
        if (overflow !== 3'b100) begin
            n_fail++;
            $display("FAIL drop_overflow: got %b, want 100", overflow);
        end
        extra = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid !== 1'b0) extra = 1'b1;
        end
        n_checks++;
        if (extra !== 1'b0 || overflow !== 3'b000) begin
            n_fail++;
            $display("FAIL drop_no_second_eof: got extra=%b ovf=%b, want 0 000", extra, overflow);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [15:0] exp_w [3];
        bit ok;
        exp_w[0] = 16'h0001;
        exp_w[1] = 16'h2002;
        exp_w[2] = 16'h4003;
        out_ready = 1'b0;
        s_run     = {10'd0, 10'd2, 10'd1};
        s_valid   = 3'b011;
        im_end    = 1'b1;
        tick();
        s_valid = '0;
        im_end  = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || draining !== 1'b1) begin
            n_fail++;
            $display("FAIL rmd_pre: got valid=%b drn=%b, want 1 1", out_valid, draining);
        end
        #2;
        RESET = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, out_data, overflow, draining, dbg_state} !== 23'd0) begin
            n_fail++;
            $display("FAIL rmd_async: got valid=%b data=%h ovf=%b drn=%b st=%0d, want all 0",
                     out_valid, out_data, overflow, draining, dbg_state);
        end
        #2;
        RESET = 1'b0;
        tick();
        out_ready = 1'b1;
        s_run     = {10'd3, 10'd2, 10'd1};
        s_valid   = 3'b111;
        tick();
        s_valid = '0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            wait_valid(ok);
            n_checks++;
            if (!ok || out_data !== exp_w[i]) begin
                n_fail++;
                $display("FAIL rmd_word%0d: got ok=%b data=%h, want %h", i, ok, out_data, exp_w[i]);
            end
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rmd_idle: out_valid=%b data=%h, want 0", out_valid, out_data);
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_single_run();
        test_simultaneous();
        test_backpressure();
        test_frame_end();
        test_frame_wrap();
        test_drain_drop();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rle_stream_scheduler.md
Name: rle_stream_scheduler

Overview:
- Merges the three 10-bit run-length streams from the RLE encoder onto one 16-bit word link with valid/ready handshake, for the downstream decoder, SPI or UART path.
- Buffers each stream in a small FIFO and grants the link round-robin.
- Emits an end-of-frame marker word once the frame-end strobe arrives and all buffered runs have drained.
- Sits between the encoder and the link or decoder inside the image-processing pipeline.

Parameters:
- DEPTH, 4: entries per stream FIFO; power of 2, at least 2.
- RUN_W, 10: run-length width. The word format below is fixed for 10; other values are unsupported.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- s_run[0..2]  in  3x10  run lengths from encoder streams 1, 2, 3.
- s_valid  in  3  per-stream strobe; one cycle per run; no backpressure to the encoder.
- im_end  in  1  one-cycle frame-end strobe from the encoder.
- out_data  out  16  {eof, id[1:0], frame[2:0], run[9:0]}.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the word.
- overflow  out  3  sticky per-stream flag: a run was dropped this frame.
- draining  out  1  high in the DRAIN and EOF states.

Behaviour:
- Reset values (asynchronous):
  - out_valid=0, out_data=0, overflow=0, draining=0.
  - FIFOs empty; round-robin pointer = stream 2, so stream 0 has first priority.
  - frame counter=0; state RUN.
- FIFO write:
  - In RUN, s_valid[i] at edge k writes s_run[i] to FIFO i.
  - If FIFO i is full, the run is dropped and overflow[i] is set.
  - A write and a read on the same FIFO in the same cycle are both honoured; a full FIFO being read that cycle does not drop.
- Output register:
  - Loads when out_valid=0 or (out_valid and out_ready).
  - out_data and out_valid stay stable while out_valid=1 and out_ready=0.
  - Full throughput of one word per cycle when out_ready stays high.
- Arbitration:
  - Among non-empty FIFOs, pick the first index after the last granted one, modulo 3.
  - The pointer updates only when a pop occurs.
- Latency: a run written at edge k into an empty system appears with out_valid=1 after edge k+1.
- Run word format: eof=0, id=i (0..2), frame=frame counter, run=popped value.
- States:
  - RUN: normal operation. im_end -> DRAIN. An im_end coinciding with s_valid still writes that run.
  - DRAIN: s_valid is ignored, and each ignored strobe sets overflow[i]. Arbitration continues. When all FIFOs are empty and no pop is pending -> EOF.
  - EOF: load the word {1, 2'b11, frame, 10'd0} through the output register. When that word is accepted (out_valid and out_ready), increment frame (3-bit wrap 7->0), clear overflow, and go to RUN.
- im_end while in DRAIN or EOF is ignored (no second marker).
- Run value 0 is legal and is forwarded as is.
- RESET asserted mid-frame aborts immediately: no EOF word is emitted and buffered runs are lost.

Test Plan:
- Reset then single run: s_valid=001, s_run0=37, out_ready=1 -> out_data 0x0000|(0<<13)|37 = 0x0025 one cycle after the write edge; out_valid low afterwards.
- Simultaneous runs: s_valid=111 with runs 5/6/7 in one cycle, out_ready=1 -> words with id 0, 1, 2 in that order (0x0005, 0x2006, 0x4007) on consecutive cycles.
- Backpressure and overflow:
  - Hold out_ready=0 and send 6 runs on stream 1 -> first word held stable; FIFO plus output register absorb DEPTH+1=5 runs; overflow=010.
  - Release out_ready -> 5 words, values in order.
- Frame end: queue 3 runs, pulse im_end, out_ready=1 -> 3 run words, then 0xE000. Frame field of the next frame's words = 1. overflow clears when 0xE000 is accepted.
- Frame wrap and DRAIN drop:
  - 8 empty frames -> EOF words 0xE000, 0xE400, ..., 0xFC00, then 0xE000.
  - s_valid during DRAIN -> not forwarded; overflow bit set.
- Reset mid-DRAIN with out_valid=1 -> all outputs 0 asynchronously; the next frame starts at frame=0 with stream 0 priority.
